// File: rtl/wb_mem_slave_pkg.sv
// Shared types and helpers for the pipelined Wishbone memory responder:
// request-queue entry layout, slot states, latency limits, byte-lane merge.
package wb_mem_slave_pkg;

    // Countdown wide enough for the largest supported latency.
    localparam int CNT_W       = $clog2(8);
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 7;

    // One outstanding request as captured at acceptance.
    typedef struct packed {
        logic [31:0]      adr;
        logic             we;
        logic [3:0]       sel;
        logic [31:0]      dat;
        logic [CNT_W-1:0] count;
    } wb_req_t;

    // Life cycle of a queue slot.
    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_WAITING = 2'd1,
        SLOT_READY   = 2'd2
    } slot_state_e;

    // Classify a slot from its valid flag and remaining countdown.
    function automatic slot_state_e slot_state(input logic valid, input logic [CNT_W-1:0] count);
        slot_state_e st;
        if (!valid) begin
            st = SLOT_EMPTY;
        end else if (count != {CNT_W{1'b0}}) begin
            st = SLOT_WAITING;
        end else begin
            st = SLOT_READY;
        end
        return st;
    endfunction

    // Keep a latency parameter inside the range the countdown can represent.
    function automatic int clamp_latency(input int lat);
        int r;
        if (lat < LATENCY_MIN) begin
            r = LATENCY_MIN;
        end else if (lat > LATENCY_MAX) begin
            r = LATENCY_MAX;
        end else begin
            r = lat;
        end
        return r;
    endfunction

    // Replace the byte lanes of old_word selected by sel with new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                r[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                r[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_req_queue.sv
// In-order request FIFO in which every occupied slot counts its own latency
// down each cycle; only the head may leave, and only once its count is zero.
module wb_req_queue
    import wb_mem_slave_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  wb_req_t          push_entry,
    input  logic             pop,
    input  logic             flush,
    output wb_req_t          head_entry,
    output logic             head_ready,
    output logic             full,
    output logic [OCC_W-1:0] occupancy
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    wb_req_t          slot_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [OCC_W-1:0] occ_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    slot_state_e      head_state_s;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_ONE;
        end
        return r;
    endfunction

    // Head classification and qualified push/pop; flush overrides both.
    always_comb begin
        head_state_s = slot_state(valid_r[head_r], slot_r[head_r].count);
        head_ready   = (head_state_s == SLOT_READY);
        full         = (occ_r == OCC_FULL);
        push_ok_s    = push & ~full & ~flush;
        pop_ok_s     = pop & head_ready & ~flush;
    end

    assign head_entry = slot_r[head_r];
    assign occupancy  = occ_r;

    // Slot ownership, pointers and occupancy; reset and flush empty the queue.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush) begin
            valid_r <= {DEPTH{1'b0}};
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            occ_r   <= {OCC_W{1'b0}};
        end else begin
            if (pop_ok_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= ptr_inc(head_r);
            end
            if (push_ok_s) begin
                valid_r[tail_r] <= 1'b1;
                tail_r          <= ptr_inc(tail_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   occ_r <= occ_r + OCC_ONE;
                2'b01:   occ_r <= occ_r - OCC_ONE;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Slot payloads: capture on push, count every waiting slot down by one.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (slot_r[i].count != {CNT_W{1'b0}})) begin
                slot_r[i].count <= slot_r[i].count - CNT_ONE;
            end
        end
        if (push_ok_s) begin
            slot_r[tail_r] <= push_entry;
        end
    end

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 memory responder: requests queue up, mature after a
// fixed latency, and complete strictly in order against a word RAM.
module wb_mem_slave
    import wb_mem_slave_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h00001000,
    parameter int          LATENCY      = 1,
    parameter int          QUEUE_DEPTH  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_stall_o
);

    localparam int               IDX_W      = $clog2(DEPTH_WORDS);
    localparam int               OCC_W      = $clog2(QUEUE_DEPTH + 1);
    localparam int               LAT_EFF    = clamp_latency(LATENCY);
    localparam logic [CNT_W-1:0] LOAD_COUNT = CNT_W'(LAT_EFF - 1);
    localparam logic [31:0]      SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0]      mem_r [DEPTH_WORDS];
    logic             ack_r;
    logic [31:0]      dat_r;

    wb_req_t          req_s;
    wb_req_t          head_s;
    logic             head_ready_s;
    logic             full_s;
    logic [OCC_W-1:0] occ_s;
    logic             push_s;
    logic             pop_fire_s;
    logic             flush_s;
    logic [31:0]      off_s;
    logic             in_range_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rd_dat_s;
    logic             unused_s;

    // Request capture and queue control; the countdown starts at LATENCY-1.
    always_comb begin
        req_s.adr   = wb_adr_i;
        req_s.we    = wb_we_i;
        req_s.sel   = wb_sel_i;
        req_s.dat   = wb_dat_i;
        req_s.count = LOAD_COUNT;
        push_s      = wb_cyc_i & wb_stb_i;
        flush_s     = ~wb_cyc_i;
        pop_fire_s  = head_ready_s & wb_cyc_i;
    end

    wb_req_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (push_s),
        .push_entry (req_s),
        .pop        (pop_fire_s),
        .flush      (flush_s),
        .head_entry (head_s),
        .head_ready (head_ready_s),
        .full       (full_s),
        .occupancy  (occ_s)
    );

    // Head address decode; an address below the base wraps to a huge offset
    // and therefore also lands out of range.
    always_comb begin
        off_s      = head_s.adr - BASE_ADDRESS;
        in_range_s = (off_s < SPAN_BYTES);
        idx_s      = off_s[IDX_W+1:2];
        if (!head_s.we && in_range_s) begin
            rd_dat_s = mem_r[idx_s];
        end else begin
            rd_dat_s = 32'h0000_0000;
        end
    end

    // Write commit at pop, lane-gated; out-of-range writes are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_ni && pop_fire_s && head_s.we && in_range_s) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], head_s.dat, head_s.sel);
        end
    end

    // Response register: one ack per popped request, read data only then.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else if (pop_fire_s) begin
            ack_r <= 1'b1;
            dat_r <= rd_dat_s;
        end else begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end
    end

    assign wb_ack_o   = ack_r;
    assign wb_dat_o   = dat_r;
    assign wb_stall_o = full_s;
    assign unused_s   = ^{occ_s, head_s.count, off_s[1:0]};

endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: two instances (LATENCY 1 and 3), a reference RAM
// model updated at acceptance, and an ack monitor fed by an expectation queue.
module tb_wb_mem_slave;

    localparam logic [31:0] BASE  = 32'h00001000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [31:0] adr   [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic [3:0]  sel   [2];
    logic        ack   [2];
    logic        stall [2];

    wb_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDRESS(BASE), .LATENCY(1), .QUEUE_DEPTH(2)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
        .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]),
        .wb_ack_o(ack[0]), .wb_stall_o(stall[0]));

    wb_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDRESS(BASE), .LATENCY(3), .QUEUE_DEPTH(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
        .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]),
        .wb_ack_o(ack[1]), .wb_stall_o(stall[1]));

    typedef struct {
        int          d;
        bit          is_read;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] ref_mem [2][DEPTH];
    int          errors = 0;
    int          checks = 0;
    int          cycle_no = 0;
    int          ack_cnt [2];
    int          ack_cycle [$];
    logic [31:0] last_rd [2];
    int          last_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        cycle_no++;
        for (int d = 0; d < 2; d++) begin
            if (ack[d] === 1'b1) begin
                ack_cnt[d]++;
                ack_cycle.push_back(cycle_no);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {31'b0, ack[d]}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_dut", 32'(d), 32'(e.d));
                    if (e.is_read) begin
                        check("rd_data", rdat[d], e.dat);
                        last_rd[d] = rdat[d];
                    end
                end
            end else begin
                check("dat_idle_zero", rdat[d], 32'h0);
            end
        end
    end

    // Reference behaviour: in-order completion means the result is fixed at acceptance.
    task automatic model_accept(input int d, input bit w, input logic [31:0] a,
                                input logic [31:0] dt, input logic [3:0] s);
        exp_t e;
        bit   inr;
        int   idx;
        inr = (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
        idx = int'((a - BASE) >> 2);
        e.d = d;
        e.is_read = !w;
        e.dat = 32'h0;
        if (inr) begin
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) ref_mem[d][idx][8*b +: 8] = dt[8*b +: 8];
                end
            end else begin
                e.dat = ref_mem[d][idx];
            end
        end
        exp_q.push_back(e);
    endtask

    // Issue one request, holding it while stalled; returns #1 after acceptance edge.
    task automatic do_req(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] dt, input logic [3:0] s);
        int waits = 0;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = dt; sel[d] = s;
        while (stall[d] !== 1'b0 && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (stall[d] !== 1'b0) begin
            check("stall_timeout", {31'b0, stall[d]}, 32'h0);
            stb[d] = 1'b0;
        end else begin
            model_accept(d, w, a, dt, s);
            @(posedge clk); #1;
            stb[d] = 1'b0;
        end
        last_wait = waits;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain();
        int b = 0;
        while (exp_q.size() > 0 && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int w4 [4];
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; adr[d] = 32'h0;
            wdat[d] = 32'h0; sel[d] = 4'h0; ack_cnt[d] = 0; last_rd[d] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ack", {31'b0, ack[d]}, 32'h0);
            check("rst_stall", {31'b0, stall[d]}, 32'h0);
            check("rst_dat", rdat[d], 32'h0);
        end
        rst_n = 1'b1;
        idle(1);

        // Preload the low 32 words of both memories.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 32; k++) begin
                do_req(d, 1'b1, BASE + 32'(4 * k), (k == 0) ? 32'hDEADBEEF : $urandom, 4'hF);
            end
            wait_drain();
        end
        idle(2);

        // Single read, LATENCY=1: ack in the cycle after the edge following acceptance.
        do_req(0, 1'b0, 32'h00001000, 32'h0, 4'h0);
        check("t1_no_stall", 32'(last_wait), 32'h0);
        check("t1_no_early_ack", {31'b0, ack[0]}, 32'h0);
        @(posedge clk); #1;
        check("t1_ack", {31'b0, ack[0]}, 32'h1);
        check("t1_dat", rdat[0], 32'hDEADBEEF);
        @(posedge clk); #1;
        check("t1_ack_once", {31'b0, ack[0]}, 32'h0);
        wait_drain();

        // Back-to-back reads never stall and ack on consecutive cycles.
        c0 = ack_cycle.size();
        for (int k = 0; k < 3; k++) begin
            do_req(0, 1'b0, 32'h00001000 + 32'(4 * k), 32'h0, 4'h0);
            check("t2_no_stall", 32'(last_wait), 32'h0);
        end
        wait_drain();
        check("t2_ack_count", 32'(ack_cycle.size() - c0), 32'd3);
        if (ack_cycle.size() >= c0 + 3) begin
            check("t2_consec_a", 32'(ack_cycle[c0+1] - ack_cycle[c0]), 32'd1);
            check("t2_consec_b", 32'(ack_cycle[c0+2] - ack_cycle[c0+1]), 32'd1);
        end

        // Byte-lane merge and sel=0 write.
        do_req(0, 1'b1, 32'h00001010, 32'hAAAAAAAA, 4'hF);
        do_req(0, 1'b1, 32'h00001010, 32'h11223344, 4'b0101);
        do_req(0, 1'b0, 32'h00001010, 32'h0, 4'h0);
        wait_drain();
        check("t3_merge", last_rd[0], 32'hAA22AA44);
        do_req(0, 1'b1, 32'h00001010, 32'hFFFFFFFF, 4'b0000);
        do_req(0, 1'b0, 32'h00001010, 32'h0, 4'h0);
        wait_drain();
        check("t3_sel0_nowrite", last_rd[0], 32'hAA22AA44);

        // Full-queue stall: LATENCY=3, QUEUE_DEPTH=2, four pipelined reads.
        idle(2);
        c0 = ack_cnt[1];
        for (int k = 0; k < 4; k++) begin
            do_req(1, 1'b0, BASE + 32'(4 * (4 + k)), 32'h0, 4'h0);
            w4[k] = last_wait;
            if (k == 1) check("t4_stall_after_two", {31'b0, stall[1]}, 32'h1);
        end
        check("t4_first_no_wait", 32'(w4[0]), 32'h0);
        check("t4_second_no_wait", 32'(w4[1]), 32'h0);
        check("t4_third_waited", {31'b0, (w4[2] > 0)}, 32'h1);
        wait_drain();
        idle(4);
        check("t4_ack_total", 32'(ack_cnt[1] - c0), 32'd4);

        // Abort with two reads outstanding: no acks, then a fresh cycle works.
        do_req(1, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
        do_req(1, 1'b0, BASE + 32'hC, 32'h0, 4'h0);
        cyc[1] = 1'b0;
        c0 = ack_cnt[1];
        @(posedge clk); #1;
        exp_q.delete();
        idle(8);
        check("t5_abort_no_ack", 32'(ack_cnt[1] - c0), 32'h0);
        do_req(1, 1'b0, BASE + 32'h14, 32'h0, 4'h0);
        wait_drain();
        check("t5_after_abort", last_rd[1], ref_mem[1][5]);

        // Reset mid-burst on the LATENCY=1 instance.
        do_req(0, 1'b0, BASE + 32'h4, 32'h0, 4'h0);
        do_req(0, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        check("t6_rst_ack", {31'b0, ack[0]}, 32'h0);
        check("t6_rst_stall", {31'b0, stall[0]}, 32'h0);
        check("t6_rst_dat", rdat[0], 32'h0);
        rst_n = 1'b1;
        c0 = ack_cnt[0];
        idle(4);
        check("t6_no_ack_after_rst", 32'(ack_cnt[0] - c0), 32'h0);
        do_req(0, 1'b0, BASE, 32'h0, 4'h0);
        wait_drain();
        check("t6_ram_kept", last_rd[0], 32'hDEADBEEF);

        // Out-of-range read and write.
        do_req(0, 1'b0, 32'h00000FFC, 32'h0, 4'h0);
        wait_drain();
        check("t7_oor_read_zero", last_rd[0], 32'h0);
        c0 = ack_cnt[0];
        do_req(0, 1'b1, BASE + 32'(DEPTH * 4), 32'h12345678, 4'hF);
        do_req(0, 1'b1, 32'h00000FFC, 32'h87654321, 4'hF);
        do_req(0, 1'b0, BASE, 32'h0, 4'h0);
        wait_drain();
        check("t7_oor_acked", 32'(ack_cnt[0] - c0), 32'd3);
        check("t7_ram_unchanged", last_rd[0], 32'hDEADBEEF);

        // Randomized traffic against the reference model on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int it = 0; it < 150; it++) begin
                logic [31:0] a;
                if ($urandom_range(0, 9) < 2) idle($urandom_range(1, 2));
                a = 32'h00000FF0 + 32'(4 * $urandom_range(0, 35)) + 32'($urandom_range(0, 3));
                do_req(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            end
            wait_drain();
            idle(3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
